reflector_bank: RTL and testbench
=================================

# reflector_bank

Parametrised multi-table successor to the single fixed reflector stage of the Enigma datapath. Holds `N_TABLES` independently loadable substitution tables over an `N_SYM`-letter alphabet. After each load it builds the inverse table and validates the wiring in a multi-cycle build pass. It serves forward (encrypt) or inverse (decrypt) lookups through a valid/ready stream with one registered output stage, and sits between the rotor stack's forward and return paths.

## Interface
Parameters:
- `N_SYM`, 26, alphabet size.
- `SYM_W`, 8, symbol width.
- `BASE`, 65, code of symbol index 0 (`'A'`).
- `N_TABLES`, 4, number of wiring tables.
- `TSEL_W`, `$clog2(N_TABLES)`, table-select width.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset_n` in 1: reset, synchronous, active-low.
- `cfg_we` in 1: load strobe.
- `cfg_sel` in `TSEL_W`: table to load.
- `cfg_table` in `N_SYM*SYM_W`: entry i at `[(N_SYM-1-i)*SYM_W +: SYM_W]`, so entry 0 is in the MSBs.
- `busy` out 1: build pass in progress.
- `cfg_err` out 1: result of the last build; 1 means the table was rejected.
- `tbl_valid` out `N_TABLES`: per-table usable flag.
- `in_valid` in 1, `in_ready` out 1: input handshake.
- `in_sym` in `SYM_W`: input symbol.
- `in_dec` in 1: 0 selects forward lookup, 1 selects inverse lookup.
- `in_sel` in `TSEL_W`: table used for this lookup.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_sym` out `SYM_W`: result symbol.
- `out_err` out 1: the lookup was not translated.

## Operation
State machine: IDLE and BUILD.
- IDLE + `cfg_we`:
  - `fwd[cfg_sel]` ← `cfg_table`.
  - `tbl_valid[cfg_sel]` ← 0.
  - `idx` ← 0, `seen` ← 0, error accumulator ← 0.
  - Next state BUILD; `busy` = 1 from the next cycle.
- BUILD, one entry per cycle:
  - Compute e = `fwd[idx]` − `BASE`.
  - If e ≥ `N_SYM` (unsigned, so codes below `BASE` also fail) or `seen[e]` is set, the error accumulator is set.
  - Otherwise `inv[e]` ← `BASE` + idx and `seen[e]` ← 1.
  - On idx = `N_SYM`−1: go to IDLE, `tbl_valid[cfg_sel]` ← !err, `cfg_err` ← err.
  - The pass always takes exactly `N_SYM` cycles.
- `cfg_we` in BUILD is ignored. Loading a table invalidates only that table; the other tables keep serving.
- Lookup accepted when `in_valid` and `in_ready` are both high:
  - Let k = `in_sym` − `BASE`.
  - If k is in range and `tbl_valid[in_sel]` is set: `out_sym` = `in_dec` ? `inv[in_sel][k]` : `fwd[in_sel][k]`, and `out_err` = 0.
  - Otherwise `out_sym` = `in_sym` (passthrough) and `out_err` = 1.
- `in_ready` = IDLE && !`cfg_we` && (!`out_valid` || `out_ready`). A load strobe has priority over a lookup in the same cycle.
- Output register:
  - `out_valid` is set on acceptance.
  - `out_valid` clears on `out_ready` when no new acceptance occurs in that cycle.
  - `out_sym` and `out_err` hold stable while `out_valid` && !`out_ready`.

## Timing
- Reset (`reset_n` = 0 at an edge):
  - State IDLE; `busy`, `cfg_err`, `out_valid`, `out_err` = 0; `out_sym` = 0; `tbl_valid` = 0.
  - Table contents are not reset.
  - Reset during BUILD aborts the pass, and no table is valid afterwards.
- Lookup latency: 1 cycle, from acceptance edge to `out_valid`.
- Throughput: 1 lookup per cycle while `out_ready` is held high.
- Load: `tbl_valid` and `cfg_err` update `N_SYM` cycles after the `cfg_we` edge. `busy` is high for exactly those `N_SYM` cycles.
- A held output is unaffected by a load or a build pass.

## Configuration
- `REFLECTOR_INVOLUTION_CHECK_EN` defined:
  - In BUILD, an entry is also an error if e = idx (a fixed point) or `fwd[e]` ≠ `BASE` + idx.
  - Only true reflectors (fixed-point-free involutions) become valid.
- Undefined: only the permutation check runs, so general substitution tables (rotor wirings, plugboards) are accepted.

## Test plan
- Load UKW-B `"YRUHQSLDPXNGOKMIEBFZCWVJAT"` into table 0. Expect `busy` for 26 cycles, then `tbl_valid[0]` = 1 and `cfg_err` = 0. Lookups give fwd 0x41→0x59 and dec 0x59→0x41.
- With the macro undefined, load rotor I `"EKMFLGDQVZNTOWYHXUSPAIBRCJ"` into table 1. Expect valid; fwd 0x41→0x45 and dec 0x45→0x41. With the macro defined, the same load gives `cfg_err` = 1 and `tbl_valid[1]` = 0.
- Load a table with entry 1 equal to entry 0 (`"AA…"`). Expect `cfg_err` = 1; a lookup of 0x42 returns 0x42 with `out_err` = 1.
- Send `in_sym` = 0x30 and 0x5B to a valid table. Each returns passthrough with `out_err` = 1.
- Backpressure: stream 4 symbols with `out_ready` low for 3 cycles. The first result holds stable, `in_ready` stays low, and no symbol is lost or duplicated.
- Pulse `reset_n` low at build cycle 10. Afterwards `busy` = 0, `tbl_valid` = 0, and a lookup returns `out_err` = 1.

Source files
------------

// File: rtl/reflector_bank.sv
// reflector_bank: multi-table substitution reflector with inverse build and a valid/ready lookup stream.
// Optional macro REFLECTOR_INVOLUTION_CHECK_EN: accept only fixed-point-free involutions.
module reflector_bank #(
   parameter int N_SYM    = 26,
   parameter int SYM_W    = 8,
   parameter int BASE     = 65,
   parameter int N_TABLES = 4,
   parameter int TSEL_W   = $clog2(N_TABLES)
)(
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     cfg_we,
   input  logic [TSEL_W-1:0]        cfg_sel,
   input  logic [N_SYM*SYM_W-1:0]   cfg_table,
   output logic                     busy,
   output logic                     cfg_err,
   output logic [N_TABLES-1:0]      tbl_valid,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SYM_W-1:0]         in_sym,
   input  logic                     in_dec,
   input  logic [TSEL_W-1:0]        in_sel,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SYM_W-1:0]         out_sym,
   output logic                     out_err
);
   localparam int IDX_W = $clog2(N_SYM);
   typedef enum logic {IDLE, BUILD} state_t;
   state_t state, state_nx;
   logic [SYM_W-1:0] fwd [N_TABLES][N_SYM];
   logic [SYM_W-1:0] inv [N_TABLES][N_SYM];
   logic [N_SYM-1:0] seen;
   logic [IDX_W-1:0] idx, e_i, k_i;
   logic [TSEL_W-1:0] lsel;
   logic [SYM_W-1:0] e, k, ent_sym;
   logic err_acc, ent_err, last, start, accept, hit;

   assign start   = state == IDLE && cfg_we;
   assign e       = fwd[lsel][idx] - SYM_W'(BASE);
   assign e_i     = IDX_W'(e);
   assign ent_sym = SYM_W'(BASE) + SYM_W'(idx);
   assign last    = idx == IDX_W'(N_SYM - 1);
   assign k       = in_sym - SYM_W'(BASE);
   assign k_i     = IDX_W'(k);
   assign hit     = k < SYM_W'(N_SYM) && tbl_valid[in_sel];
   assign accept  = in_valid && in_ready;
`ifdef REFLECTOR_INVOLUTION_CHECK_EN
   assign ent_err = e >= SYM_W'(N_SYM) || seen[e_i] || e_i == idx || fwd[lsel][e_i] != ent_sym;
`else
   assign ent_err = e >= SYM_W'(N_SYM) || seen[e_i];
`endif

   // state register
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // next state: a load starts a pass that always runs N_SYM entries
   always_comb begin
      state_nx = state == IDLE ? (cfg_we ? BUILD : IDLE) : (last ? IDLE : BUILD);
   end

   // FSM outputs: a load strobe wins over a lookup in the same cycle
   always_comb begin
      busy     = state == BUILD;
      in_ready = state == IDLE && !cfg_we && (!out_valid || out_ready);
   end

   // table storage is never reset; inverse entries fill in as the pass walks the forward table
   always_ff @(posedge clk) begin
      if (start)
         for (int i = 0; i < N_SYM; i++) fwd[cfg_sel][i] <= cfg_table[(N_SYM-1-i)*SYM_W +: SYM_W];
      if (state == BUILD && !ent_err) inv[lsel][e_i] <= ent_sym;
   end

   // build bookkeeping and per-table validity
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tbl_valid <= '0;
         cfg_err   <= 1'b0;
         idx       <= '0;
         seen      <= '0;
         err_acc   <= 1'b0;
         lsel      <= '0;
      end else if (start) begin
         lsel               <= cfg_sel;
         tbl_valid[cfg_sel] <= 1'b0;
         idx                <= '0;
         seen               <= '0;
         err_acc            <= 1'b0;
      end else if (state == BUILD) begin
         idx     <= idx + IDX_W'(1);
         err_acc <= err_acc | ent_err;
         if (!ent_err) seen[e_i] <= 1'b1;
         if (last) begin
            tbl_valid[lsel] <= !(err_acc | ent_err);
            cfg_err         <= err_acc | ent_err;
         end
      end
   end

   // registered lookup result; holds while the consumer stalls
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_sym   <= '0;
         out_err   <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_sym   <= hit ? (in_dec ? inv[in_sel][k_i] : fwd[in_sel][k_i]) : in_sym;
         out_err   <= !hit;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_reflector_bank.sv
// tb_reflector_bank: directed checks of loading, validation, lookups, backpressure and reset abort.
module tb_reflector_bank;
   localparam logic [26*8-1:0] UKW_B = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
   localparam logic [26*8-1:0] ROT_I = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
   localparam logic [26*8-1:0] DUP   = "AACDEFGHIJKLMNOPQRSTUVWXYZ";

   logic clk = 0, reset_n = 0, cfg_we = 0, busy, cfg_err;
   logic [1:0] cfg_sel = 0, in_sel = 0;
   logic [26*8-1:0] cfg_table = '0;
   logic [3:0] tbl_valid;
   logic in_valid = 0, in_ready, in_dec = 0, out_valid, out_ready = 1, out_err;
   logic [7:0] in_sym = 0, out_sym;
   int n_cmp = 0, n_bad = 0;

   reflector_bank dut (
      .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_table(cfg_table),
      .busy(busy), .cfg_err(cfg_err), .tbl_valid(tbl_valid),
      .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym), .in_dec(in_dec), .in_sel(in_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_sym(out_sym), .out_err(out_err)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, want);
      end
   endtask

   task automatic load(input logic [1:0] sel, input logic [26*8-1:0] tbl);
      int n = 0;
      cfg_we = 1; cfg_sel = sel; cfg_table = tbl;
      @(posedge clk); #1;
      cfg_we = 0;
      while (busy && n < 40) begin
         n++;
         @(posedge clk); #1;
      end
      check("busy_len", n, 26);
   endtask

   task automatic lookup(input string tag, input logic [7:0] sym, input logic dec, input logic [1:0] sel,
                         input logic [7:0] want, input logic want_err);
      in_valid = 1; in_sym = sym; in_dec = dec; in_sel = sel; out_ready = 1;
      #1;
      check({tag, "_rdy"}, in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0;
      check({tag, "_vld"}, out_valid, 1);
      check({tag, "_sym"}, out_sym, want);
      check({tag, "_err"}, out_err, want_err);
   endtask

   initial begin
      logic [7:0] src [4];
      logic [7:0] exp_q [4];
      int i, j;
      src = '{8'h41, 8'h42, 8'h43, 8'h44};
      exp_q = '{8'h59, 8'h52, 8'h55, 8'h48};
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", busy, 0);
      check("rst_cfg_err", cfg_err, 0);
      check("rst_tbl_valid", tbl_valid, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_sym", out_sym, 0);
      check("rst_out_err", out_err, 0);
      reset_n = 1;
      @(posedge clk); #1;
      check("idle_ready", in_ready, 1);

      load(0, UKW_B);
      check("ukw_valid", tbl_valid, 4'b0001);
      check("ukw_cfg_err", cfg_err, 0);
      lookup("ukw_fA", 8'h41, 0, 0, 8'h59, 0);
      lookup("ukw_dY", 8'h59, 1, 0, 8'h41, 0);
      lookup("ukw_fZ", 8'h5A, 0, 0, 8'h54, 0);

      load(1, ROT_I);
`ifdef REFLECTOR_INVOLUTION_CHECK_EN
      check("rot_cfg_err", cfg_err, 1);
      check("rot_valid", tbl_valid, 4'b0001);
      lookup("rot_fA", 8'h41, 0, 1, 8'h41, 1);
`else
      check("rot_cfg_err", cfg_err, 0);
      check("rot_valid", tbl_valid, 4'b0011);
      lookup("rot_fA", 8'h41, 0, 1, 8'h45, 0);
      lookup("rot_dE", 8'h45, 1, 1, 8'h41, 0);
      lookup("rot_fZ", 8'h5A, 0, 1, 8'h4A, 0);
`endif

      load(2, DUP);
      check("dup_cfg_err", cfg_err, 1);
      check("dup_valid2", tbl_valid[2], 0);
      check("dup_valid0", tbl_valid[0], 1);
      lookup("dup_B", 8'h42, 0, 2, 8'h42, 1);
      lookup("ukw_still", 8'h42, 0, 0, 8'h52, 0);

      lookup("lo_30", 8'h30, 0, 0, 8'h30, 1);
      lookup("hi_5B", 8'h5B, 0, 0, 8'h5B, 1);
      lookup("lo_40", 8'h40, 1, 0, 8'h40, 1);

      i = 0; j = 0;
      for (int c = 0; c < 40 && j < 4; c++) begin
         @(posedge clk); #1;
         in_valid = i < 4; in_sym = src[i < 4 ? i : 3]; in_dec = 0; in_sel = 0;
         out_ready = !(c >= 1 && c <= 3);
         #1;
         if (out_valid && !out_ready) begin
            check("bp_hold_sym", out_sym, exp_q[j]);
            check("bp_ready_low", in_ready, 0);
         end
         if (out_valid && out_ready) begin
            check("bp_order", out_sym, exp_q[j]);
            j++;
         end
         if (in_valid && in_ready) i++;
      end
      in_valid = 0; out_ready = 1;
      check("bp_sent", i, 4);
      check("bp_recv", j, 4);
      @(posedge clk); #1;
      check("bp_drained", out_valid, 0);

      cfg_we = 1; cfg_sel = 0; cfg_table = UKW_B;
      @(posedge clk); #1;
      cfg_we = 0;
      repeat (10) @(posedge clk);
      #1;
      check("abort_busy_pre", busy, 1);
      reset_n = 0;
      @(posedge clk); #1;
      reset_n = 1;
      check("abort_busy", busy, 0);
      check("abort_valid", tbl_valid, 0);
      repeat (30) @(posedge clk);
      #1;
      check("abort_busy_late", busy, 0);
      check("abort_valid_late", tbl_valid, 0);
      lookup("abort_A", 8'h41, 0, 0, 8'h41, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
